// File: rtl/irq_request_reg.sv
// Interrupt request register front end: per-line synchroniser, edge/level sensing,
// pending hold until acknowledge, and request freeze during INTA.

module irq_request_lane #(
    parameter int SYNC_STAGES = 2
) (
    input  logic clk,
    input  logic rst,
    input  logic line_i,
    input  logic level_i,
    input  logic init_i,
    input  logic freeze_i,
    input  logic ack_i,
    output logic irr_o
);

    logic [SYNC_STAGES-1:0] sync_q;
    logic s, edge_det, set_edge;
    logic prev_q, lvl_q;
    logic pend_q, pend_d;
    logic irr_q, irr_d;

    assign s        = sync_q[SYNC_STAGES-1];
    assign edge_det = s & ~prev_q;
    assign irr_o    = irr_q;

    always_ff @(posedge clk) begin
        if (rst) begin
            sync_q <= '0;
            prev_q <= 1'b0;
            lvl_q  <= 1'b0;
            pend_q <= 1'b0;
            irr_q  <= 1'b0;
        end else begin
            sync_q[0] <= line_i;
            for (int k = 1; k < SYNC_STAGES; k++) sync_q[k] <= sync_q[k-1];
            // Tracking s every cycle also covers init: a line already high yields no edge.
            prev_q <= s;
            lvl_q  <= level_i;
            pend_q <= pend_d;
            irr_q  <= irr_d;
        end
    end

    always_comb begin
        set_edge = 1'b0;
        pend_d   = pend_q;
        irr_d    = irr_q;
        if (init_i) begin
            irr_d  = 1'b0;
            pend_d = 1'b0;
        end else if (level_i) begin
            pend_d = 1'b0;
            if (!freeze_i) irr_d = s;
            if (ack_i)     irr_d = 1'b0;
        end else begin
            if (freeze_i) begin
                pend_d = pend_q | edge_det;
            end else begin
                set_edge = edge_det | pend_q;
                pend_d   = 1'b0;
            end
            // Leaving level mode drops the level-derived request; a fresh set beats an ack.
            if (lvl_q)    irr_d = 1'b0;
            if (ack_i)    irr_d = 1'b0;
            if (set_edge) irr_d = 1'b1;
        end
    end

endmodule

module irq_request_reg #(
    parameter int NUM_IRQ     = 8,
    parameter int IDX_W       = $clog2(NUM_IRQ),
    parameter int SYNC_STAGES = 2
) (
    input  logic               clk,
    input  logic               rst,
    input  logic [NUM_IRQ-1:0] irq_lines,
    input  logic [NUM_IRQ-1:0] trig_mode,
    input  logic               init,
    input  logic               freeze,
    input  logic               ack,
    input  logic [IDX_W-1:0]   ack_idx,
    output logic [NUM_IRQ-1:0] irr,
    output logic               any_req,
    output logic               spurious
);

    logic [NUM_IRQ-1:0] ack_hot;
    logic               hit;
    logic               spurious_q, spurious_d;

    for (genvar i = 0; i < NUM_IRQ; i++) begin : g_lane
        assign ack_hot[i] = ack && (ack_idx == IDX_W'(i));

        irq_request_lane #(
            .SYNC_STAGES(SYNC_STAGES)
        ) u_lane (
            .clk      (clk),
            .rst      (rst),
            .line_i   (irq_lines[i]),
            .level_i  (trig_mode[i]),
            .init_i   (init),
            .freeze_i (freeze),
            .ack_i    (ack_hot[i] & irr[i]),
            .irr_o    (irr[i])
        );
    end

    // Out-of-range indices decode to no lane, so they fall out as misses.
    assign hit        = |(ack_hot & irr);
    assign spurious_d = ack & ~init & ~hit;
    assign any_req    = |irr;
    assign spurious   = spurious_q;

    always_ff @(posedge clk) begin
        if (rst) spurious_q <= 1'b0;
        else     spurious_q <= spurious_d;
    end

endmodule

// File: tb/tb_irq_request_reg.sv
// Self-checking bench for irq_request_reg: vector table on an 8-line/2-stage
// instance plus a hand sequence on a 16-line/3-stage instance.

module tb_irq_request_reg;

    typedef struct {
        logic [7:0] lines;
        logic [7:0] trig;
        logic       init;
        logic       frz;
        logic       ack;
        logic [2:0] idx;
        logic [7:0] exp_irr;
        logic       exp_spur;
    } vec_t;

    typedef struct {
        int          sel;
        int          row;
        logic [15:0] irr;
        logic        spur;
    } exp_t;

    logic clk = 1'b0;
    always #5 clk = ~clk;

    logic        rst;
    logic [7:0]  lines8, trig8, irr8;
    logic        init8, frz8, ack8, any8, spur8;
    logic [2:0]  idx8;
    logic [15:0] lines16, trig16, irr16;
    logic        init16, frz16, ack16, any16, spur16;
    logic [3:0]  idx16;

    int n_cmp = 0;
    int n_err = 0;
    vec_t tbl[$];
    exp_t sbq[$];

    irq_request_reg #(.NUM_IRQ(8), .SYNC_STAGES(2)) dut8 (
        .clk(clk), .rst(rst), .irq_lines(lines8), .trig_mode(trig8), .init(init8),
        .freeze(frz8), .ack(ack8), .ack_idx(idx8), .irr(irr8), .any_req(any8),
        .spurious(spur8)
    );

    irq_request_reg #(.NUM_IRQ(16), .SYNC_STAGES(3)) dut16 (
        .clk(clk), .rst(rst), .irq_lines(lines16), .trig_mode(trig16), .init(init16),
        .freeze(frz16), .ack(ack16), .ack_idx(idx16), .irr(irr16), .any_req(any16),
        .spurious(spur16)
    );

    task automatic chk(input string nm, input int row, input logic [15:0] act, input logic [15:0] exp);
        n_cmp++;
        if (act !== exp) begin
            n_err++;
            $display("FAIL %s row %0d: got %0h want %0h", nm, row, act, exp);
        end
    endtask

    task automatic add(input logic [7:0] l, input logic [7:0] t, input logic in, input logic fz,
                       input logic ak, input logic [2:0] ix, input logic [7:0] ei, input logic es);
        vec_t v;
        v.lines = l; v.trig = t; v.init = in; v.frz = fz; v.ack = ak; v.idx = ix;
        v.exp_irr = ei; v.exp_spur = es;
        tbl.push_back(v);
    endtask

    task automatic pop_check();
        exp_t e;
        logic [15:0] ai;
        logic as, aa;
        e = sbq.pop_front();
        if (e.sel == 0) begin ai = {8'h00, irr8}; as = spur8;  aa = any8;  end
        else            begin ai = irr16;         as = spur16; aa = any16; end
        chk(e.sel == 0 ? "irr8" : "irr16", e.row, ai, e.irr);
        chk(e.sel == 0 ? "spurious8" : "spurious16", e.row, {15'h0, as}, {15'h0, e.spur});
        chk(e.sel == 0 ? "any_req8" : "any_req16", e.row, {15'h0, aa}, {15'h0, |e.irr});
    endtask

    task automatic step8(input int row, input vec_t v);
        exp_t e;
        @(negedge clk);
        lines8 = v.lines; trig8 = v.trig; init8 = v.init; frz8 = v.frz;
        ack8 = v.ack; idx8 = v.idx;
        e.sel = 0; e.row = row; e.irr = {8'h00, v.exp_irr}; e.spur = v.exp_spur;
        sbq.push_back(e);
        @(posedge clk);
        #1;
        pop_check();
    endtask

    task automatic step16(input int row, input logic [15:0] l, input logic ak, input logic [3:0] ix,
                          input logic [15:0] ei, input logic es);
        exp_t e;
        @(negedge clk);
        lines16 = l; ack16 = ak; idx16 = ix;
        e.sel = 1; e.row = row; e.irr = ei; e.spur = es;
        sbq.push_back(e);
        @(posedge clk);
        #1;
        pop_check();
    endtask

    initial begin
        #200000;
        $display("FAIL watchdog: simulation did not finish in time");
        $fatal(1);
    end

    initial begin
        rst = 1'b1;
        lines8 = '0; trig8 = '0; init8 = 1'b0; frz8 = 1'b0; ack8 = 1'b1; idx8 = 3'd6;
        lines16 = '0; trig16 = '0; init16 = 1'b0; frz16 = 1'b0; ack16 = 1'b1; idx16 = 4'd6;
        repeat (3) @(posedge clk);
        #1;
        chk("rst_irr8", 0, {8'h0, irr8}, 16'h0);
        chk("rst_spurious8", 0, {15'h0, spur8}, 16'h0);
        chk("rst_any_req8", 0, {15'h0, any8}, 16'h0);
        chk("rst_irr16", 0, irr16, 16'h0);
        chk("rst_spurious16", 0, {15'h0, spur16}, 16'h0);
        @(negedge clk);
        rst = 1'b0; ack8 = 1'b0; ack16 = 1'b0;

        // lines trig init frz ack idx exp_irr exp_spur
        // edge capture on line 3
        add(8'h08, 8'h00, 0, 0, 0, 0, 8'h00, 0);
        add(8'h00, 8'h00, 0, 0, 0, 0, 8'h00, 0);
        add(8'h00, 8'h00, 0, 0, 0, 0, 8'h08, 0);
        add(8'h00, 8'h00, 0, 0, 0, 0, 8'h08, 0);
        add(8'h00, 8'h00, 0, 0, 1, 3, 8'h00, 0);
        add(8'h00, 8'h00, 0, 0, 0, 0, 8'h00, 0);
        // level follow on line 5
        add(8'h20, 8'hFF, 0, 0, 0, 0, 8'h00, 0);
        add(8'h20, 8'hFF, 0, 0, 0, 0, 8'h00, 0);
        add(8'h20, 8'hFF, 0, 0, 0, 0, 8'h20, 0);
        add(8'h20, 8'hFF, 0, 0, 0, 0, 8'h20, 0);
        add(8'h20, 8'hFF, 0, 0, 1, 5, 8'h00, 0);
        add(8'h20, 8'hFF, 0, 0, 0, 0, 8'h20, 0);
        add(8'h00, 8'hFF, 0, 0, 0, 0, 8'h20, 0);
        add(8'h00, 8'hFF, 0, 0, 0, 0, 8'h20, 0);
        add(8'h00, 8'hFF, 0, 0, 0, 0, 8'h00, 0);
        // freeze buffering on line 1
        add(8'h02, 8'h00, 0, 1, 0, 0, 8'h00, 0);
        add(8'h00, 8'h00, 0, 1, 0, 0, 8'h00, 0);
        add(8'h00, 8'h00, 0, 1, 0, 0, 8'h00, 0);
        add(8'h00, 8'h00, 0, 1, 0, 0, 8'h00, 0);
        add(8'h00, 8'h00, 0, 0, 0, 0, 8'h02, 0);
        add(8'h00, 8'h00, 0, 0, 1, 1, 8'h00, 0);
        // ack/edge collision on line 2, then spurious ack on idle line 6
        add(8'h04, 8'h00, 0, 0, 0, 0, 8'h00, 0);
        add(8'h00, 8'h00, 0, 0, 0, 0, 8'h00, 0);
        add(8'h04, 8'h00, 0, 0, 0, 0, 8'h04, 0);
        add(8'h04, 8'h00, 0, 0, 0, 0, 8'h04, 0);
        add(8'h04, 8'h00, 0, 0, 1, 2, 8'h04, 0);
        add(8'h04, 8'h00, 0, 0, 1, 6, 8'h04, 1);
        add(8'h04, 8'h00, 0, 0, 0, 0, 8'h04, 0);
        add(8'h04, 8'h00, 0, 0, 1, 2, 8'h00, 0);
        add(8'h00, 8'h00, 0, 0, 0, 0, 8'h00, 0);
        // init with lines 0 and 7 held high
        add(8'h81, 8'h00, 0, 0, 0, 0, 8'h00, 0);
        add(8'h81, 8'h00, 0, 0, 0, 0, 8'h00, 0);
        add(8'h81, 8'h00, 0, 0, 0, 0, 8'h81, 0);
        add(8'h81, 8'h00, 1, 0, 0, 0, 8'h00, 0);
        add(8'h81, 8'h00, 0, 0, 0, 0, 8'h00, 0);
        add(8'h81, 8'h00, 0, 0, 0, 0, 8'h00, 0);
        add(8'h00, 8'h00, 0, 0, 0, 0, 8'h00, 0);
        add(8'h81, 8'h00, 0, 0, 0, 0, 8'h00, 0);
        add(8'h81, 8'h00, 0, 0, 0, 0, 8'h00, 0);
        add(8'h81, 8'h00, 0, 0, 0, 0, 8'h81, 0);
        add(8'h81, 8'h00, 1, 0, 1, 0, 8'h00, 0);
        add(8'h81, 8'h00, 0, 0, 0, 0, 8'h00, 0);
        // mode changes, and level behaviour under freeze
        add(8'h81, 8'h81, 0, 0, 0, 0, 8'h81, 0);
        add(8'h81, 8'h00, 0, 0, 0, 0, 8'h00, 0);
        add(8'h81, 8'h00, 0, 0, 0, 0, 8'h00, 0);
        add(8'h81, 8'hFF, 0, 1, 0, 0, 8'h00, 0);
        add(8'h81, 8'hFF, 0, 0, 0, 0, 8'h81, 0);
        add(8'h81, 8'hFF, 0, 1, 1, 7, 8'h01, 0);
        add(8'h81, 8'hFF, 0, 1, 0, 0, 8'h01, 0);
        add(8'h81, 8'hFF, 0, 0, 0, 0, 8'h81, 0);
        add(8'h00, 8'h00, 0, 0, 0, 0, 8'h00, 0);

        for (int r = 0; r < tbl.size(); r++) step8(r + 1, tbl[r]);

        // 16 lines, 3 sync stages: line 15 pulses for one cycle
        step16(101, 16'h8000, 0, 4'd0,  16'h0000, 0);
        step16(102, 16'h0000, 0, 4'd0,  16'h0000, 0);
        step16(103, 16'h0000, 0, 4'd0,  16'h0000, 0);
        step16(104, 16'h0000, 0, 4'd0,  16'h8000, 0);
        step16(105, 16'h0000, 0, 4'd0,  16'h8000, 0);
        step16(106, 16'h0000, 1, 4'd15, 16'h0000, 0);
        step16(107, 16'h0000, 1, 4'd15, 16'h0000, 1);
        step16(108, 16'h0000, 0, 4'd0,  16'h0000, 0);

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
        $finish;
    end

endmodule

// File: doc/irq_request_reg.md
Name: irq_request_reg

Overview:
Parametrised interrupt request register (IRR) front end for the PIC. It synchronises N raw interrupt lines and applies per-channel edge or level sensing. It holds pending requests until the priority resolver acknowledges them and freezes new requests during an INTA sequence. Its outputs feed the priority resolver and ISR logic.

Parameters:
NUM_IRQ, 8, number of interrupt channels (2..32)
IDX_W, $clog2(NUM_IRQ), width of the channel index
SYNC_STAGES, 2, flip-flop stages in the input synchroniser per line (1..4)

Ports:
clk  in  1  system clock; all state updates on rising edge
rst  in  1  synchronous active-high reset
irq_lines  in  NUM_IRQ  raw asynchronous request lines, active high
trig_mode  in  NUM_IRQ  per-channel sense mode: 1 = level, 0 = edge (bit-wise generalisation of ICW1 LTIM)
init  in  1  one-cycle pulse on ICW1 write; clears request state
freeze  in  1  high during INTA sequence; blocks new requests from reaching irr
ack  in  1  one-cycle pulse: clear request ack_idx
ack_idx  in  IDX_W  channel being acknowledged (resolver's winner)
irr  out  NUM_IRQ  registered pending-request vector
any_req  out  1  OR-reduction of irr
spurious  out  1  registered one-cycle pulse: ack hit a non-pending or out-of-range channel

Behaviour:
- Reset (rst=1 at clock edge): sync chain, prev sample, pending_edge, irr and spurious are all 0. any_req is 0.
- Synchroniser: s[i] is the output of the SYNC_STAGES chain. A line that rises before clock edge 0 reaches s at edge SYNC_STAGES-1 and irr at edge SYNC_STAGES.
- prev[i] <= s[i] every cycle. edge_det[i] = s[i] & ~prev[i].
- Edge channel (trig_mode[i]=0):
  - edge_det sets irr[i]. The bit stays latched after the line falls and clears only on ack or init.
  - Re-request needs a new rising edge. A line held high after ack does not re-set the bit.
- Level channel (trig_mode[i]=1):
  - With freeze=0, irr[i] <= s[i] every cycle.
  - An ack clears the bit for that cycle. It re-asserts the next cycle if s[i] is still 1.
- Freeze:
  - While freeze=1, no irr bit may rise (level bits hold their value; edge sets are blocked). Clears from ack still apply.
  - Edges detected during freeze are latched into pending_edge[i].
  - On the first cycle with freeze=0, pending_edge bits are ORed into irr for edge channels, then pending_edge clears.
  - Level channels need no pending store; they resample.
- Ack:
  - Clears irr[ack_idx] unless an edge channel has a new set (edge_det or pending_edge release) in the same cycle. The new edge wins and the bit stays 1.
  - If irr[ack_idx]==0 or ack_idx>=NUM_IRQ at the ack edge, spurious=1 for exactly the next cycle and irr is unchanged.
  - Ack while rst=1 is ignored.
- Init:
  - Clears irr and pending_edge, and loads prev<=s so lines already high do not produce an edge.
  - Init overrides ack, freeze release and edge sets in the same cycle. Init itself never causes spurious.
- Mode change on channel i takes effect at the next edge:
  - Edge->level: irr[i] follows s[i].
  - Level->edge: irr[i] is cleared and no edge is inferred from the existing high level.
- Lines held high through reset produce an edge request SYNC_STAGES+1 cycles after rst falls. This is intended; software issues init after configuration.
- any_req is combinational from registered irr; no other combinational input-to-output paths.

Test Plan:
1. Edge capture, NUM_IRQ=8, SYNC_STAGES=2: irq_lines[3] rises then falls after 1 cycle -> irr=8'h08 at edge 2 after rise and stays 8'h08. ack,ack_idx=3 -> irr=8'h00 next cycle, spurious=0.
2. Level follow: trig_mode=8'hFF, irq_lines[5] held high -> irr=8'h20. ack idx 5 -> irr=8'h00 for one cycle, then 8'h20. Line drops -> irr=8'h00 two cycles later.
3. Freeze buffering: freeze=1, edge on line 1 -> irr bit 1 stays 0 during freeze. Freeze drops -> irr[1]=1 on the first cycle after release.
4. Ack/edge collision: irr[2]=1; ack idx 2 in the same cycle as a fresh edge_det[2] -> irr[2] stays 1. Ack idx 6 with irr[6]=0 -> spurious pulses for 1 cycle, irr unchanged.
5. Init: lines 0 and 7 high with irr=8'h81, pulse init -> irr=8'h00 next cycle and no re-set while the lines stay high. Lines fall and rise -> bits set again.
6. Parameter sweep: NUM_IRQ=16, SYNC_STAGES=3: edge on line 15 -> irr=16'h8000 at edge 3. ack_idx=15 clears it.
